// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, one-cycle-latency memory between a data
// stage and an instruction fetch stage.
//
// Arbitration: data wins by default. A fetch that keeps losing is promoted once it has
// been denied STARVE_LIMIT consecutive cycles. Grants are combinational from the current
// requests and registered state. Read data returns one cycle after the grant and is
// tagged by a small response-owner register.
//
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   d_req, d_we, d_addr, d_wdata         data-stage request (level, held until d_gnt)
//   d_gnt, d_rvalid, d_rdata             data-stage grant and read return
//   i_req, i_addr                        fetch request (level, held until i_gnt)
//   i_gnt, i_rvalid, i_rdata             fetch grant and read return
//   mem_addr, mem_wdata, mem_we          shared memory request
//   mem_rdata                            shared memory read data (one cycle after addr)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnData = 2'd1,
    OwnInst = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  // Raw arbitration result; the state registers are held in reset anyway, so only the
  // outputs need gating by rst_n.
  logic arb_d, arb_i;

  always_comb begin
    arb_d = 1'b0;
    arb_i = 1'b0;
    if (i_req && (!d_req || (starve_q == Limit))) begin
      arb_i = 1'b1;
    end else if (d_req) begin
      arb_d = 1'b1;
    end
  end

  // Reset forces all grants and the write strobe low without waiting for a clock edge.
  assign d_gnt  = arb_d & rst_n;
  assign i_gnt  = arb_i & rst_n;
  assign mem_we = d_gnt & d_we;

  // Fetch has no write data, so mem_wdata always carries the data-stage value.
  assign mem_addr  = arb_i ? i_addr : d_addr;
  assign mem_wdata = d_wdata;

  // Both returns come straight from memory; consumers qualify with their rvalid.
  assign d_rdata  = mem_rdata;
  assign i_rdata  = mem_rdata;
  assign d_rvalid = (owner_q == OwnData);
  assign i_rvalid = (owner_q == OwnInst);

  always_comb begin
    starve_d = starve_q;
    owner_d  = OwnNone;
    // A fetch that is not pending, or has just been served, forgets its history.
    if (!i_req || arb_i) begin
      starve_d = 4'd0;
    end else if (starve_q != Limit) begin
      starve_d = starve_q + 4'd1;
    end
    if (arb_d && !d_we) begin
      owner_d = OwnData;
    end else if (arb_i) begin
      owner_d = OwnInst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
      owner_q  <= OwnNone;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural model (starvation count as an
// integer, one pending-response slot, a word memory) predicts every output each cycle;
// directed sequences add literal expectations for the key scenarios.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_req, d_we, i_req;
  logic [AW-1:0] d_addr, i_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid, i_gnt, i_rvalid, mem_we;
  logic [DW-1:0] d_rdata, i_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input int idx);
    return (idx == 4) ? 32'hA5A5_A5A5 : (32'hC0DE_0000 + DW'(idx));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory: answers the DUT one cycle after the address, accepts writes.
  logic [DW-1:0] env_mem [64];
  bit   [63:0]   env_wr;
  always @(posedge clk) begin
    mem_rdata <= env_wr[mem_addr[7:2]] ? env_mem[mem_addr[7:2]] : pattern(int'(mem_addr[7:2]));
    if (mem_we) begin
      env_mem[mem_addr[7:2]] <= mem_wdata;
      env_wr[mem_addr[7:2]]  <= 1'b1;
    end
  end

  // ---------------- behavioural model ----------------
  int            m_starve;   // consecutive cycles fetch has been refused
  int            m_pend;     // 0 none, 1 data read, 2 fetch read outstanding
  int            m_pend_idx;
  logic [DW-1:0] m_mem [64];
  bit   [63:0]   m_wr;
  logic          e_d, e_i;

  function automatic logic [DW-1:0] m_word(input int idx);
    return m_wr[idx] ? m_mem[idx] : pattern(idx);
  endfunction

  always_comb begin
    e_d = 1'b0;
    e_i = 1'b0;
    if (rst_n) begin
      if (d_req && i_req) begin
        if (m_starve >= LIMIT) e_i = 1'b1;
        else                   e_d = 1'b1;
      end else begin
        e_d = d_req;
        e_i = i_req;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve <= 0;
      m_pend   <= 0;
    end else begin
      if (i_req && !e_i) m_starve <= (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else               m_starve <= 0;
      m_pend <= 0;
      if (e_d && !d_we) begin
        m_pend     <= 1;
        m_pend_idx <= int'(d_addr[7:2]);
      end else if (e_i) begin
        m_pend     <= 2;
        m_pend_idx <= int'(i_addr[7:2]);
      end
      if (e_d && d_we) begin
        m_mem[d_addr[7:2]] <= d_wdata;
        m_wr[d_addr[7:2]]  <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("d_gnt", 64'(d_gnt), 64'(e_d));
    chk("i_gnt", 64'(i_gnt), 64'(e_i));
    chk("mem_we", 64'(mem_we), 64'(e_d && d_we));
    chk("d_rvalid", 64'(d_rvalid), 64'(m_pend == 1));
    chk("i_rvalid", 64'(i_rvalid), 64'(m_pend == 2));
    if (rst_n) chk("mem_addr", 64'(mem_addr), 64'(e_i ? i_addr : d_addr));
    if (!e_i) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    if (m_pend == 1) chk("d_rdata", 64'(d_rdata), 64'(m_word(m_pend_idx)));
    if (m_pend == 2) chk("i_rdata", 64'(i_rdata), 64'(m_word(m_pend_idx)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b0;
  endtask

  logic [7:0] dv, iv;
  logic [6:0] iv2;

  // Directed mix: {d_req, d_we, i_req}, d_addr, i_addr, d_wdata
  localparam int NV = 11;
  logic [2:0]    v_ctl  [NV] = '{3'b110, 3'b100, 3'b001, 3'b111, 3'b101, 3'b000,
                                 3'b101, 3'b101, 3'b101, 3'b101, 3'b000};
  logic [AW-1:0] v_da   [NV] = '{32'h80, 32'h80, 32'h0, 32'h84, 32'h84, 32'h0,
                                 32'h84, 32'h84, 32'h84, 32'h84, 32'h0};
  logic [AW-1:0] v_ia   [NV] = '{32'h0, 32'h0, 32'h80, 32'h90, 32'h90, 32'h0,
                                 32'h88, 32'h88, 32'h88, 32'h88, 32'h0};
  logic [DW-1:0] v_wd   [NV] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0BADF00D, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    idle();
    d_addr = '0; i_addr = '0; d_wdata = '0;
    rst_n  = 1'b0;
    #3;
    chk("reset_d_gnt", 64'(d_gnt), 64'd0);
    chk("reset_rvalid", 64'({d_rvalid, i_rvalid}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch-only read of 0x10.
    i_req = 1'b1; i_addr = 32'h10;
    #3 chk("fetch_gnt", 64'(i_gnt), 64'd1);
    tick(); idle();
    #3 chk("fetch_rvalid", 64'(i_rvalid), 64'd1);
    chk("fetch_rdata", 64'(i_rdata), 64'hA5A5_A5A5);
    chk("fetch_no_d_rvalid", 64'(d_rvalid), 64'd0);
    tick();

    // Data write to 0x40, then read it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
    #3 chk("wr_mem_we", 64'(mem_we), 64'd1);
    chk("wr_mem_addr", 64'(mem_addr), 64'h40);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
    tick(); idle();
    #3 chk("wr_no_rvalid", 64'({d_rvalid, i_rvalid}), 64'd0);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick(); idle();
    #3 chk("rd_back", 64'(d_rdata), 64'h1234_5678);
    tick();

    // Both held: fetch wins every fourth cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; i_req = 1'b1; i_addr = 32'h4;
    for (int c = 0; c < 8; c++) begin
      #3;
      dv[c] = d_gnt;
      iv[c] = i_gnt;
      @(posedge clk);
      #1;
    end
    chk("starve_d_seq", 64'(dv), 64'b0111_0111);
    chk("starve_i_seq", 64'(iv), 64'b1000_1000);

    // Fetch denied twice, drops for a cycle, then needs three fresh denials.
    for (int c = 0; c < 7; c++) begin
      i_req = (c != 2);
      #3 iv2[c] = i_gnt;
      @(posedge clk);
      #1;
    end
    chk("starve_restart", 64'(iv2), 64'b100_0000);

    // Data read then fetch read on consecutive cycles.
    idle();
    d_req = 1'b1; d_addr = 32'h10;
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h44;
    #3 chk("alt_c1_valid", 64'({d_rvalid, i_rvalid}), 64'b10);
    chk("alt_c1_data", 64'(d_rdata), 64'hA5A5_A5A5);
    tick(); idle();
    #3 chk("alt_c2_valid", 64'({d_rvalid, i_rvalid}), 64'b01);
    tick();

    // Reset asserted mid-cycle while a data read is granted.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    #1 chk("pre_rst_gnt", 64'(d_gnt), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_gnt_drop", 64'({d_gnt, i_gnt, mem_we}), 64'd0);
    @(posedge clk);
    #4 chk("rst_no_rvalid", 64'({d_rvalid, i_rvalid}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3 chk("post_rst_gnt", 64'(d_gnt), 64'd1);
    tick(); idle();
    #3 chk("post_rst_rvalid", 64'(d_rvalid), 64'd1);
    chk("post_rst_rdata", 64'(d_rdata), 64'hC0DE_0002);
    tick();

    // Mixed directed vectors, checked by the model every cycle.
    for (int v = 0; v < NV; v++) begin
      {d_req, d_we, i_req} = v_ctl[v];
      d_addr  = v_da[v];
      i_addr  = v_ia[v];
      d_wdata = v_wd[v];
      tick();
    end
    idle();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
